// File: rtl/attn_pkg.sv
// attn_pkg: shared constants and types for the Q/K/V ingress buffer.
package attn_pkg;
   localparam int ELEM_W = 16;
   localparam int DATA_W = 128;
   localparam int MAX_HEAD_DIM = DATA_W / ELEM_W;
   typedef enum logic [1:0] {IDLE, LOAD, FULL} ingress_state_e;
   typedef enum logic [1:0] {ERR_NONE, ERR_CFG, ERR_ALIGN, ERR_RANGE} ingress_err_e;
   typedef logic [1:0] mat_sel_t;
endpackage

// File: rtl/attn_ingress_chan.sv
// attn_ingress_chan: one matrix channel - row RAM, written-row bitmap, address decode and ready/loaded.
module attn_ingress_chan import attn_pkg::*; #(
   parameter int MAX_SEQ_LEN = 16,
   parameter int ADDR_W = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic active,
   input  logic [$clog2(MAX_SEQ_LEN):0] seq_len,
   input  logic [1:0] hd_shift,
   input  logic valid,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data,
   input  logic [$clog2(MAX_SEQ_LEN)-1:0] rd_row,
   output logic ready,
   output logic loaded,
   output logic err_align,
   output logic err_range,
   output logic [DATA_W-1:0] rd_word
);
   localparam int RW = $clog2(MAX_SEQ_LEN);
   localparam int LW = RW + 1;
   logic [DATA_W-1:0] mem [MAX_SEQ_LEN];
   logic [MAX_SEQ_LEN-1:0] bitmap, need;
   logic [ADDR_W-1:0] row;
   logic fire, ok;
   assign row = addr >> hd_shift;
   assign fire = valid && ready;
   assign err_align = fire && ((addr & ((ADDR_W'(1) << hd_shift) - ADDR_W'(1))) != '0);
   assign err_range = fire && !err_align && (row >= ADDR_W'(seq_len));
   assign ok = fire && !err_align && !err_range;
   for (genvar i = 0; i < MAX_SEQ_LEN; i++) begin : g_need
      assign need[i] = LW'(i) < seq_len;
   end
   // an empty config (reset) must never read as loaded
   assign loaded = (seq_len != '0) && ((bitmap & need) == need);
   assign ready = active && !loaded;
   assign rd_word = mem[rd_row];
   always_ff @(posedge clk)
      if (ok) mem[row[RW-1:0]] <= data;
   always_ff @(posedge clk)
      bitmap <= (!rst_n || clear) ? '0 : ok ? bitmap | (MAX_SEQ_LEN'(1) << row[RW-1:0]) : bitmap;
endmodule

// File: rtl/attn_qkv_ingress_buffer.sv
// attn_qkv_ingress_buffer: Q/K/V load receiver with IDLE/LOAD/FULL control, registered read port and error capture.
// Optional beat/stall counters are enabled with ATTN_INGRESS_STATS_EN.
module attn_qkv_ingress_buffer import attn_pkg::*; #(
   parameter int MAX_SEQ_LEN = 16,
   parameter int ADDR_W = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_start,
   input  logic [31:0] seq_length,
   input  logic [31:0] head_dim,
   input  logic release_req,
   input  logic q_valid,
   input  logic k_valid,
   input  logic v_valid,
   input  logic [ADDR_W-1:0] q_addr,
   input  logic [ADDR_W-1:0] k_addr,
   input  logic [ADDR_W-1:0] v_addr,
   input  logic [DATA_W-1:0] q_data,
   input  logic [DATA_W-1:0] k_data,
   input  logic [DATA_W-1:0] v_data,
   output logic q_ready,
   output logic k_ready,
   output logic v_ready,
   input  logic rd_en,
   input  mat_sel_t rd_sel,
   input  logic [$clog2(MAX_SEQ_LEN)-1:0] rd_row,
   output logic [DATA_W-1:0] rd_data,
   output logic rd_valid,
   output logic q_loaded,
   output logic k_loaded,
   output logic v_loaded,
   output logic all_loaded,
   output logic busy,
   output logic err,
   output logic [1:0] err_code
`ifdef ATTN_INGRESS_STATS_EN
   ,
   output logic [15:0] q_beats,
   output logic [15:0] k_beats,
   output logic [15:0] v_beats,
   output logic [15:0] q_stall,
   output logic [15:0] k_stall,
   output logic [15:0] v_stall
`endif
);
   localparam int LW = $clog2(MAX_SEQ_LEN) + 1;
   ingress_state_e state, state_n;
   ingress_err_e err_e;
   logic [LW-1:0] seq_len;
   logic [1:0] hd_shift, shift_n;
   logic cfg_ok;
   logic [2:0] valid_v, ready_v, loaded_v, align_v, range_v;
   logic [DATA_W-1:0] row_q, row_k, row_v;
   assign valid_v = {v_valid, k_valid, q_valid};
   assign shift_n = (head_dim == 32'd1) ? 2'd0 : (head_dim == 32'd2) ? 2'd1 : (head_dim == 32'd4) ? 2'd2 : 2'd3;
   assign cfg_ok = (seq_length != 32'd0) && (seq_length <= 32'(MAX_SEQ_LEN)) &&
      (head_dim == 32'd1 || head_dim == 32'd2 || head_dim == 32'd4 || head_dim == 32'd8);
   attn_ingress_chan #(.MAX_SEQ_LEN(MAX_SEQ_LEN), .ADDR_W(ADDR_W)) u_q (
      .clk(clk), .rst_n(rst_n), .clear(load_start), .active(state == LOAD), .seq_len(seq_len),
      .hd_shift(hd_shift), .valid(valid_v[0]), .addr(q_addr), .data(q_data), .rd_row(rd_row),
      .ready(ready_v[0]), .loaded(loaded_v[0]), .err_align(align_v[0]), .err_range(range_v[0]), .rd_word(row_q));
   attn_ingress_chan #(.MAX_SEQ_LEN(MAX_SEQ_LEN), .ADDR_W(ADDR_W)) u_k (
      .clk(clk), .rst_n(rst_n), .clear(load_start), .active(state == LOAD), .seq_len(seq_len),
      .hd_shift(hd_shift), .valid(valid_v[1]), .addr(k_addr), .data(k_data), .rd_row(rd_row),
      .ready(ready_v[1]), .loaded(loaded_v[1]), .err_align(align_v[1]), .err_range(range_v[1]), .rd_word(row_k));
   attn_ingress_chan #(.MAX_SEQ_LEN(MAX_SEQ_LEN), .ADDR_W(ADDR_W)) u_v (
      .clk(clk), .rst_n(rst_n), .clear(load_start), .active(state == LOAD), .seq_len(seq_len),
      .hd_shift(hd_shift), .valid(valid_v[2]), .addr(v_addr), .data(v_data), .rd_row(rd_row),
      .ready(ready_v[2]), .loaded(loaded_v[2]), .err_align(align_v[2]), .err_range(range_v[2]), .rd_word(row_v));
   assign {v_ready, k_ready, q_ready} = ready_v;
   assign {v_loaded, k_loaded, q_loaded} = loaded_v;
   assign busy = state == LOAD;
   assign all_loaded = state == FULL;
   assign err = err_e != ERR_NONE;
   assign err_code = err_e;
   // load_start outranks release and loaded completion
   always_comb begin
      state_n = load_start ? (cfg_ok ? LOAD : IDLE) :
         (state == LOAD && &loaded_v) ? FULL :
         (state == FULL && release_req) ? IDLE : state;
   end
   always_ff @(posedge clk)
      if (!rst_n) begin
         state <= IDLE;
         err_e <= ERR_NONE;
         seq_len <= '0;
         hd_shift <= '0;
      end else begin
         state <= state_n;
         if (load_start && cfg_ok) begin
            seq_len <= LW'(seq_length);
            hd_shift <= shift_n;
         end
         if (load_start) err_e <= cfg_ok ? ERR_NONE : ERR_CFG;
         else if (err_e == ERR_NONE && |(align_v | range_v)) err_e <= |align_v ? ERR_ALIGN : ERR_RANGE;
      end
   always_ff @(posedge clk)
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_data <= '0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) rd_data <= (rd_sel == 2'd0) ? row_q : (rd_sel == 2'd1) ? row_k : (rd_sel == 2'd2) ? row_v : '0;
      end
`ifdef ATTN_INGRESS_STATS_EN
   logic [15:0] beats [3];
   logic [15:0] stall [3];
   for (genvar c = 0; c < 3; c++) begin : g_stat
      always_ff @(posedge clk)
         if (!rst_n || load_start) begin
            beats[c] <= '0;
            stall[c] <= '0;
         end else begin
            if (valid_v[c] && ready_v[c] && beats[c] != 16'hFFFF) beats[c] <= beats[c] + 16'd1;
            if (state == LOAD && valid_v[c] && !ready_v[c] && stall[c] != 16'hFFFF) stall[c] <= stall[c] + 16'd1;
         end
   end
   assign {q_beats, k_beats, v_beats} = {beats[0], beats[1], beats[2]};
   assign {q_stall, k_stall, v_stall} = {stall[0], stall[1], stall[2]};
`endif
endmodule

// File: tb/tb_attn_qkv_ingress_buffer.sv
// tb_attn_qkv_ingress_buffer: directed scenarios for the Q/K/V ingress buffer.
module tb_attn_qkv_ingress_buffer;
   import attn_pkg::*;
   logic clk = 1'b0, rst_n = 1'b0, load_start = 1'b0, release_req = 1'b0;
   logic [31:0] seq_length = '0, head_dim = '0;
   logic q_valid = 1'b0, k_valid = 1'b0, v_valid = 1'b0;
   logic [31:0] q_addr = '0, k_addr = '0, v_addr = '0;
   logic [127:0] q_data = '0, k_data = '0, v_data = '0;
   logic rd_en = 1'b0;
   logic [1:0] rd_sel = '0;
   logic [3:0] rd_row = '0;
   logic q_ready, k_ready, v_ready, rd_valid, q_loaded, k_loaded, v_loaded, all_loaded, busy, err;
   logic [127:0] rd_data;
   logic [1:0] err_code;
`ifdef ATTN_INGRESS_STATS_EN
   logic [15:0] q_beats, k_beats, v_beats, q_stall, k_stall, v_stall;
`endif
   int checks = 0, errors = 0;
   attn_qkv_ingress_buffer dut (
      .clk(clk), .rst_n(rst_n), .load_start(load_start), .seq_length(seq_length), .head_dim(head_dim),
      .release_req(release_req), .q_valid(q_valid), .k_valid(k_valid), .v_valid(v_valid),
      .q_addr(q_addr), .k_addr(k_addr), .v_addr(v_addr), .q_data(q_data), .k_data(k_data), .v_data(v_data),
      .q_ready(q_ready), .k_ready(k_ready), .v_ready(v_ready), .rd_en(rd_en), .rd_sel(rd_sel), .rd_row(rd_row),
      .rd_data(rd_data), .rd_valid(rd_valid), .q_loaded(q_loaded), .k_loaded(k_loaded), .v_loaded(v_loaded),
      .all_loaded(all_loaded), .busy(busy), .err(err), .err_code(err_code)
`ifdef ATTN_INGRESS_STATS_EN
      , .q_beats(q_beats), .k_beats(k_beats), .v_beats(v_beats),
      .q_stall(q_stall), .k_stall(k_stall), .v_stall(v_stall)
`endif
   );
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   function automatic logic [127:0] diag(input int r);
      logic [127:0] b;
      b = 128'h0100;
      return b << (16 * r);
   endfunction
   task automatic start(input int sl, input int hd);
      load_start = 1'b1;
      seq_length = 32'(sl);
      head_dim = 32'(hd);
      tick();
      load_start = 1'b0;
   endtask
   task automatic drive(input int ch, input logic v, input logic [31:0] a, input logic [127:0] d);
      case (ch)
         0: begin q_valid = v; q_addr = a; q_data = d; end
         1: begin k_valid = v; k_addr = a; k_data = d; end
         default: begin v_valid = v; v_addr = a; v_data = d; end
      endcase
   endtask
   task automatic beats(input logic [2:0] m, input int r0, input int n, input logic [127:0] base);
      for (int r = r0; r < r0 + n; r++) begin
         for (int c = 0; c < 3; c++) if (m[c]) drive(c, 1'b1, 32'(r * 4), base + 128'(r));
         tick();
      end
      for (int c = 0; c < 3; c++) if (m[c]) drive(c, 1'b0, '0, '0);
   endtask
   task automatic read(input logic [1:0] sel, input logic [3:0] row);
      rd_en = 1'b1;
      rd_sel = sel;
      rd_row = row;
      tick();
      rd_en = 1'b0;
   endtask
   task automatic test_reset;
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if ({q_ready, k_ready, v_ready, q_loaded, k_loaded, v_loaded, all_loaded, busy, err, rd_valid, err_code} !== 12'd0 || rd_data !== '0) begin
         errors++;
         $display("FAIL reset_outputs got flags=%b err_code=%0d rd_data=%h expected all zero",
            {q_ready, k_ready, v_ready, q_loaded, k_loaded, v_loaded, all_loaded, busy, err, rd_valid}, err_code, rd_data);
      end
      rst_n = 1'b1;
      tick();
   endtask
   task automatic test_config;
      start(4, 3);
      checks++;
      if ({busy, err, err_code} !== 4'b0101) begin
         errors++;
         $display("FAIL cfg_bad_head got busy=%b err=%b code=%0d expected 0 1 1", busy, err, err_code);
      end
      start(17, 4);
      checks++;
      if ({busy, err, err_code} !== 4'b0101) begin
         errors++;
         $display("FAIL cfg_bad_len got busy=%b err=%b code=%0d expected 0 1 1", busy, err, err_code);
      end
   endtask
   task automatic test_identity;
      logic [2:0] rdy, ld;
      start(4, 4);
      checks++;
      if ({busy, err, err_code} !== 4'b1000) begin
         errors++;
         $display("FAIL id_start got busy=%b err=%b code=%0d expected 1 0 0", busy, err, err_code);
      end
      for (int ch = 0; ch < 3; ch++) begin
         for (int r = 0; r < 4; r++) begin
            drive(ch, 1'b1, 32'(r * 4), diag(r));
            rdy = {v_ready, k_ready, q_ready};
            checks++;
            if (rdy[ch] !== 1'b1) begin
               errors++;
               $display("FAIL id_ready ch=%0d row=%0d got %b expected 1", ch, r, rdy[ch]);
            end
            tick();
         end
         drive(ch, 1'b0, '0, '0);
         rdy = {v_ready, k_ready, q_ready};
         ld = {v_loaded, k_loaded, q_loaded};
         checks++;
         if (rdy[ch] !== 1'b0 || ld[ch] !== 1'b1) begin
            errors++;
            $display("FAIL id_done ch=%0d got ready=%b loaded=%b expected 0 1", ch, rdy[ch], ld[ch]);
         end
      end
      checks++;
      if (all_loaded !== 1'b0) begin
         errors++;
         $display("FAIL id_all_early got %b expected 0", all_loaded);
      end
      tick();
      checks++;
      if (all_loaded !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL id_full got all_loaded=%b busy=%b expected 1 0", all_loaded, busy);
      end
      read(2'd1, 4'd2);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 128'h0100_0000_0000) begin
         errors++;
         $display("FAIL id_read_k2 got valid=%b data=%h expected 1 %h", rd_valid, rd_data, 128'h0100_0000_0000);
      end
      tick();
      checks++;
      if (rd_valid !== 1'b0 || rd_data !== 128'h0100_0000_0000) begin
         errors++;
         $display("FAIL id_read_hold got valid=%b data=%h expected 0 %h", rd_valid, rd_data, 128'h0100_0000_0000);
      end
      read(2'd0, 4'd3);
      checks++;
      if (rd_data !== diag(3)) begin
         errors++;
         $display("FAIL id_read_q3 got %h expected %h", rd_data, diag(3));
      end
      read(2'd3, 4'd1);
      checks++;
      if (rd_data !== '0) begin
         errors++;
         $display("FAIL id_read_reserved got %h expected 0", rd_data);
      end
`ifdef ATTN_INGRESS_STATS_EN
      checks++;
      if (q_beats !== 16'd4 || q_stall !== 16'd0) begin
         errors++;
         $display("FAIL id_stats got beats=%0d stall=%0d expected 4 0", q_beats, q_stall);
      end
`endif
   endtask
   task automatic test_concurrent;
      start(4, 4);
      checks++;
      if ({q_loaded, k_loaded, v_loaded, busy} !== 4'b0001) begin
         errors++;
         $display("FAIL cc_restart got loaded=%b busy=%b expected 000 1", {q_loaded, k_loaded, v_loaded}, busy);
      end
      for (int r = 0; r < 4; r++) begin
         drive(0, 1'b1, 32'(r * 4), 128'h0A000 + 128'(r));
         drive(1, 1'b1, 32'(r * 4), 128'h0B000 + 128'(r));
         drive(2, 1'b1, 32'(r * 4), 128'h0C000 + 128'(r));
         checks++;
         if ({q_ready, k_ready, v_ready} !== 3'b111) begin
            errors++;
            $display("FAIL cc_ready row=%0d got %b expected 111", r, {q_ready, k_ready, v_ready});
         end
         tick();
      end
      for (int c = 0; c < 3; c++) drive(c, 1'b0, '0, '0);
      checks++;
      if ({q_ready, k_ready, v_ready, all_loaded} !== 4'b0000) begin
         errors++;
         $display("FAIL cc_after4 got ready=%b all_loaded=%b expected 000 0", {q_ready, k_ready, v_ready}, all_loaded);
      end
      tick();
      checks++;
      if (all_loaded !== 1'b1 || err !== 1'b0) begin
         errors++;
         $display("FAIL cc_full got all_loaded=%b err=%b expected 1 0", all_loaded, err);
      end
      read(2'd2, 4'd3);
      checks++;
      if (rd_data !== 128'h0C003) begin
         errors++;
         $display("FAIL cc_read_v3 got %h expected %h", rd_data, 128'h0C003);
      end
   endtask
   task automatic test_errors;
      start(4, 4);
      drive(0, 1'b1, 32'd6, 128'hDEAD);
      tick();
      checks++;
      if (err !== 1'b1 || err_code !== 2'd2 || q_ready !== 1'b1) begin
         errors++;
         $display("FAIL err_align got err=%b code=%0d ready=%b expected 1 2 1", err, err_code, q_ready);
      end
      drive(0, 1'b1, 32'd16, 128'hBEEF);
      tick();
      drive(0, 1'b0, '0, '0);
      checks++;
      if (err_code !== 2'd2) begin
         errors++;
         $display("FAIL err_first_wins got code=%0d expected 2", err_code);
      end
      beats(3'b001, 0, 1, 128'h0);
      beats(3'b001, 2, 2, 128'h0);
      checks++;
      if (q_loaded !== 1'b0) begin
         errors++;
         $display("FAIL err_row_not_set got q_loaded=%b expected 0", q_loaded);
      end
      beats(3'b001, 1, 1, 128'h0);
      checks++;
      if (q_loaded !== 1'b1 || err_code !== 2'd2) begin
         errors++;
         $display("FAIL err_complete got q_loaded=%b code=%0d expected 1 2", q_loaded, err_code);
      end
   endtask
   task automatic test_abort;
      start(4, 4);
      beats(3'b001, 0, 3, 128'h0);
      drive(0, 1'b1, 32'd1, '0);
      tick();
      drive(0, 1'b0, '0, '0);
      checks++;
      if (err !== 1'b1 || err_code !== 2'd2) begin
         errors++;
         $display("FAIL ab_pre_err got err=%b code=%0d expected 1 2", err, err_code);
      end
      start(4, 4);
      checks++;
      if ({q_loaded, err, err_code, busy} !== 5'b00001) begin
         errors++;
         $display("FAIL ab_cleared got loaded=%b err=%b code=%0d busy=%b expected 0 0 0 1", q_loaded, err, err_code, busy);
      end
      beats(3'b001, 3, 1, 128'h0);
      checks++;
      if (q_loaded !== 1'b0) begin
         errors++;
         $display("FAIL ab_needs_all got q_loaded=%b expected 0", q_loaded);
      end
      beats(3'b001, 0, 3, 128'h0);
      checks++;
      if (q_loaded !== 1'b1) begin
         errors++;
         $display("FAIL ab_reloaded got q_loaded=%b expected 1", q_loaded);
      end
   endtask
   task automatic test_rewrite_release;
      start(4, 4);
      beats(3'b001, 0, 1, 128'h0);
      drive(0, 1'b1, 32'd4, 128'hAAAA);
      tick();
      drive(0, 1'b1, 32'd4, 128'hBBBB);
      read(2'd0, 4'd1);
      drive(0, 1'b0, '0, '0);
      checks++;
      if (rd_data !== 128'hAAAA) begin
         errors++;
         $display("FAIL rw_old_data got %h expected %h", rd_data, 128'hAAAA);
      end
      read(2'd0, 4'd1);
      checks++;
      if (rd_data !== 128'hBBBB) begin
         errors++;
         $display("FAIL rw_new_data got %h expected %h", rd_data, 128'hBBBB);
      end
      beats(3'b001, 2, 1, 128'h0);
      checks++;
      if (q_loaded !== 1'b0) begin
         errors++;
         $display("FAIL rw_partial got q_loaded=%b expected 0", q_loaded);
      end
      beats(3'b001, 3, 1, 128'h0);
      beats(3'b110, 0, 4, 128'h0);
      tick();
      checks++;
      if (all_loaded !== 1'b1 || q_loaded !== 1'b1) begin
         errors++;
         $display("FAIL rw_full got all_loaded=%b q_loaded=%b expected 1 1", all_loaded, q_loaded);
      end
      release_req = 1'b1;
      tick();
      release_req = 1'b0;
      checks++;
      if ({busy, all_loaded, q_ready, k_ready, v_ready} !== 5'b00000) begin
         errors++;
         $display("FAIL rw_release got busy=%b all=%b ready=%b expected 0 0 000", busy, all_loaded, {q_ready, k_ready, v_ready});
      end
   endtask
   task automatic test_reset_mid;
      start(4, 4);
      beats(3'b001, 0, 2, 128'h0);
      checks++;
      if (busy !== 1'b1 || rd_data !== 128'hBBBB) begin
         errors++;
         $display("FAIL rm_pre got busy=%b data=%h expected 1 %h", busy, rd_data, 128'hBBBB);
      end
      rst_n = 1'b0;
      tick();
      checks++;
      if ({q_ready, k_ready, v_ready, q_loaded, k_loaded, v_loaded, all_loaded, busy, err, rd_valid, err_code} !== 12'd0 || rd_data !== '0) begin
         errors++;
         $display("FAIL rm_outputs got flags=%b code=%0d data=%h expected all zero",
            {q_ready, k_ready, v_ready, q_loaded, k_loaded, v_loaded, all_loaded, busy, err, rd_valid}, err_code, rd_data);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || q_ready !== 1'b0) begin
         errors++;
         $display("FAIL rm_idle got busy=%b ready=%b expected 0 0", busy, q_ready);
      end
   endtask
   initial begin
      test_reset();
      test_config();
      test_identity();
      test_concurrent();
      test_errors();
      test_abort();
      test_rewrite_release();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
